// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle MIPS core: opcodes, PCSrc encodings
// and the fetch-unit state type.
package cpu_pkg;

  // Opcodes the fetch path cares about when building jump/branch targets.
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;

  // Next-PC source selection driven by the control decoder.
  // 2'b11 is not produced by the decoder and falls back to sequential.
  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_JUMP = 2'b01;
  localparam logic [1:0] PCSRC_JR   = 2'b10;

  // Fetch FSM: one idle cycle after reset, then alternate between waiting
  // on instruction memory and holding the word for the execute stage.
  typedef enum logic [1:0] {
    FETCH_IDLE = 2'b00,
    FETCH_WAIT = 2'b01,
    FETCH_HOLD = 2'b10
  } fetch_state_e;

  // Sign-extend a 16-bit branch immediate and turn it into a byte offset.
  function automatic logic [31:0] branchOffset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Purely combinational next-PC selection: jump, register jump, taken beq or
// fall-through. All arithmetic wraps modulo 2^32.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instruction,
  input  logic [1:0]  PCSrc,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc
);

  logic [31:0] jumpTarget;
  logic [31:0] regTarget;
  logic [31:0] branchTarget;
  logic        branchTaken;

  // Opcode bits and the byte-offset bits of the register target never
  // influence the target; they are folded here so they are visibly accounted for.
  logic unusedBits;
  assign unusedBits = ^{instruction[31:26], jr_target[1:0]};

  assign jumpTarget   = {pc_plus4[31:28], instruction[25:0], 2'b00};
  assign regTarget    = {jr_target[31:2], 2'b00};
  assign branchTarget = pc_plus4 + branchOffset(instruction[15:0]);
  assign branchTaken  = Branch && Zero;

  // Select the target; the unused PCSrc code behaves as sequential without branch.
  always_comb begin
    next_pc = pc_plus4;
    case (PCSrc)
      PCSRC_JUMP: next_pc = jumpTarget;
      PCSRC_JR:   next_pc = regTarget;
      PCSRC_SEQ:  next_pc = branchTaken ? branchTarget : pc_plus4;
      default:    next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch for the multi-cycle core. Requests a
// word at pc, holds it for the decoder until execute acknowledges it, then
// advances pc to the target chosen by next_pc_calc.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] instruction,
  output logic [5:0]  OpCode,
  output logic [5:0]  Funct,
  input  logic        inst_ack,
  input  logic [1:0]  PCSrc,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  fetch_state_e state;
  fetch_state_e nextState;

  logic [31:0] pcReg;
  logic [31:0] instReg;
  logic        instValidReg;
  logic [31:0] nextPc;
  logic        captureInst;
  logic        retireInst;

  next_pc_calc nextPcCalc (
    .pc_plus4    (pc_plus4),
    .instruction (instReg),
    .PCSrc       (PCSrc),
    .Branch      (Branch),
    .Zero        (Zero),
    .jr_target   (jr_target),
    .next_pc     (nextPc)
  );

  // State register; reset drops back to IDLE and abandons any pending fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and handshake decode; ready only matters in WAIT, ack only in HOLD.
  always_comb begin
    nextState   = state;
    imem_req    = 1'b0;
    captureInst = 1'b0;
    retireInst  = 1'b0;
    case (state)
      FETCH_IDLE: begin
        nextState = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          captureInst = 1'b1;
          nextState   = FETCH_HOLD;
        end
      end
      FETCH_HOLD: begin
        if (inst_ack) begin
          retireInst = 1'b1;
          nextState  = FETCH_WAIT;
        end
      end
      default: begin
        nextState = FETCH_IDLE;
      end
    endcase
  end

  // Program counter advances only when execute retires the held instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcReg <= RESET_PC;
    end else if (retireInst) begin
      pcReg <= nextPc;
    end
  end

  // Instruction register keeps its last word after retirement; only the valid flag drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      instReg      <= 32'h0000_0000;
      instValidReg <= 1'b0;
    end else if (captureInst) begin
      instReg      <= imem_rdata;
      instValidReg <= 1'b1;
    end else if (retireInst) begin
      instValidReg <= 1'b0;
    end
  end

  assign pc          = pcReg;
  assign pc_plus4    = pcReg + 32'd4;
  assign imem_addr   = pcReg;
  assign instruction = instReg;
  assign inst_valid  = instValidReg;
  assign OpCode      = instReg[31:26];
  assign Funct       = instReg[5:0];

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed vector bench for pc_fetch_unit: a cycle-by-cycle table walking
// through fetch, jumps, branches, jr, wait states, reset abort and wrap,
// followed by a back-to-back throughput sequence.
module tb_pc_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] instruction;
  logic [5:0]  OpCode;
  logic [5:0]  Funct;
  logic        inst_ack;
  logic [1:0]  PCSrc;
  logic        Branch;
  logic        Zero;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  int checkCount;
  int errorCount;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic [31:0] rdata;
    logic        ack;
    logic [1:0]  pcSrc;
    logic        br;
    logic        zero;
    logic [31:0] jrTgt;
    logic        expReq;
    logic        expValid;
    logic [31:0] expInstr;
    logic [31:0] expPc;
  } vec_t;

  vec_t vecs[$];

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .instruction (instruction),
    .OpCode      (OpCode),
    .Funct       (Funct),
    .inst_ack    (inst_ack),
    .PCSrc       (PCSrc),
    .Branch      (Branch),
    .Zero        (Zero),
    .jr_target   (jr_target),
    .pc          (pc),
    .pc_plus4    (pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset      = v.rst;
    imem_ready = v.rdy;
    imem_rdata = v.rdata;
    inst_ack   = v.ack;
    PCSrc      = v.pcSrc;
    Branch     = v.br;
    Zero       = v.zero;
    jr_target  = v.jrTgt;
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input logic rst, input logic rdy, input logic [31:0] rdata,
                        input logic ack, input logic [1:0] pcSrc, input logic br,
                        input logic zero, input logic [31:0] jrTgt,
                        input logic expReq, input logic expValid,
                        input logic [31:0] expInstr, input logic [31:0] expPc);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rdata = rdata; v.ack = ack;
    v.pcSrc = pcSrc; v.br = br; v.zero = zero; v.jrTgt = jrTgt;
    v.expReq = expReq; v.expValid = expValid; v.expInstr = expInstr; v.expPc = expPc;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] expInstr;
    checkCount = 0;
    errorCount = 0;
    reset = 1'b1; imem_ready = 1'b0; imem_rdata = '0; inst_ack = 1'b0;
    PCSrc = 2'b00; Branch = 1'b0; Zero = 1'b0; jr_target = '0;

    //     rst rdy rdata          ack src   br  z   jrTgt          req val instr          pc
    addVec(1, 0, 32'h0,          0, 2'b00, 0, 0, 32'h0,          0, 0, 32'h0,          32'h0);
    addVec(0, 0, 32'h0,          0, 2'b00, 0, 0, 32'h0,          1, 0, 32'h0,          32'h0);
    addVec(0, 1, 32'h0000_0020,  0, 2'b00, 0, 0, 32'h0,          0, 1, 32'h0000_0020,  32'h0);
    addVec(0, 1, 32'h0000_0020,  1, 2'b00, 0, 0, 32'h0,          1, 0, 32'h0000_0020,  32'h4);
    addVec(0, 1, 32'h0000_0020,  1, 2'b00, 0, 0, 32'h0,          0, 1, 32'h0000_0020,  32'h4);
    addVec(0, 1, 32'h0000_0020,  1, 2'b00, 0, 0, 32'h0,          1, 0, 32'h0000_0020,  32'h8);
    // j to 0x10, then the j 0x100 case
    addVec(0, 1, 32'h0800_0004,  0, 2'b00, 0, 0, 32'h0,          0, 1, 32'h0800_0004,  32'h8);
    addVec(0, 0, 32'h0,          1, 2'b01, 0, 0, 32'h0,          1, 0, 32'h0800_0004,  32'h10);
    addVec(0, 1, 32'h0800_0040,  0, 2'b00, 0, 0, 32'h0,          0, 1, 32'h0800_0040,  32'h10);
    addVec(0, 0, 32'h0,          1, 2'b01, 0, 0, 32'h0,          1, 0, 32'h0800_0040,  32'h100);
    // j to 0x20, beq -2 taken -> 0x1C
    addVec(0, 1, 32'h0800_0008,  0, 2'b00, 0, 0, 32'h0,          0, 1, 32'h0800_0008,  32'h100);
    addVec(0, 0, 32'h0,          1, 2'b01, 0, 0, 32'h0,          1, 0, 32'h0800_0008,  32'h20);
    addVec(0, 1, 32'h1000_FFFE,  0, 2'b00, 0, 0, 32'h0,          0, 1, 32'h1000_FFFE,  32'h20);
    addVec(0, 0, 32'h0,          1, 2'b00, 1, 1, 32'h0,          1, 0, 32'h1000_FFFE,  32'h1C);
    // beq +0 taken at 0x1C -> 0x20, then beq -2 not taken -> 0x24
    addVec(0, 1, 32'h1000_0000,  0, 2'b00, 0, 0, 32'h0,          0, 1, 32'h1000_0000,  32'h1C);
    addVec(0, 0, 32'h0,          1, 2'b00, 1, 1, 32'h0,          1, 0, 32'h1000_0000,  32'h20);
    addVec(0, 1, 32'h1000_FFFE,  0, 2'b00, 0, 0, 32'h0,          0, 1, 32'h1000_FFFE,  32'h20);
    addVec(0, 0, 32'h0,          1, 2'b00, 1, 0, 32'h0,          1, 0, 32'h1000_FFFE,  32'h24);
    // jr to 0x123 -> 0x120
    addVec(0, 1, 32'h0000_0008,  0, 2'b00, 0, 0, 32'h0,          0, 1, 32'h0000_0008,  32'h24);
    addVec(0, 0, 32'h0,          1, 2'b10, 0, 0, 32'h0000_0123,  1, 0, 32'h0000_0008,  32'h120);
    // three wait cycles (ack in WAIT ignored), capture on the fourth
    addVec(0, 0, 32'h0,          0, 2'b00, 0, 0, 32'h0,          1, 0, 32'h0000_0008,  32'h120);
    addVec(0, 0, 32'h0,          1, 2'b10, 0, 0, 32'h0000_0500,  1, 0, 32'h0000_0008,  32'h120);
    addVec(0, 0, 32'h0,          0, 2'b00, 0, 0, 32'h0,          1, 0, 32'h0000_0008,  32'h120);
    addVec(0, 1, 32'h0000_0020,  0, 2'b00, 0, 0, 32'h0,          0, 1, 32'h0000_0020,  32'h120);
    // ready in HOLD ignored; PCSrc=11 with Branch&Zero is plain sequential
    addVec(0, 1, 32'hDEAD_BEEF,  0, 2'b00, 0, 0, 32'h0,          0, 1, 32'h0000_0020,  32'h120);
    addVec(0, 0, 32'h0,          1, 2'b11, 1, 1, 32'h0,          1, 0, 32'h0000_0020,  32'h124);
    // reset abort in WAIT, stale ready in IDLE ignored
    addVec(0, 0, 32'h0,          0, 2'b00, 0, 0, 32'h0,          1, 0, 32'h0000_0020,  32'h124);
    addVec(1, 1, 32'hCAFE_F00D,  1, 2'b00, 0, 0, 32'h0,          0, 0, 32'h0,          32'h0);
    addVec(0, 1, 32'hCAFE_F00D,  0, 2'b00, 0, 0, 32'h0,          1, 0, 32'h0,          32'h0);
    // jr to 0xFFFFFFFF -> 0xFFFFFFFC, then sequential wrap to 0
    addVec(0, 1, 32'h03E0_0008,  0, 2'b00, 0, 0, 32'h0,          0, 1, 32'h03E0_0008,  32'h0);
    addVec(0, 0, 32'h0,          1, 2'b10, 0, 0, 32'hFFFF_FFFF,  1, 0, 32'h03E0_0008,  32'hFFFF_FFFC);
    addVec(0, 1, 32'h0000_0020,  0, 2'b00, 0, 0, 32'h0,          0, 1, 32'h0000_0020,  32'hFFFF_FFFC);
    addVec(0, 0, 32'h0,          1, 2'b00, 0, 0, 32'h0,          1, 0, 32'h0000_0020,  32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d imem_req", i), {31'b0, imem_req}, {31'b0, vecs[i].expReq});
      checkOutput($sformatf("v%0d inst_valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].expValid});
      checkOutput($sformatf("v%0d instruction", i), instruction, vecs[i].expInstr);
      checkOutput($sformatf("v%0d pc", i), pc, vecs[i].expPc);
      checkOutput($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].expPc);
      checkOutput($sformatf("v%0d pc_plus4", i), pc_plus4, vecs[i].expPc + 32'd4);
      expInstr = vecs[i].expInstr;
      checkOutput($sformatf("v%0d OpCode", i), {26'b0, OpCode}, {26'b0, expInstr[31:26]});
      checkOutput($sformatf("v%0d Funct", i), {26'b0, Funct}, {26'b0, expInstr[5:0]});
    end

    // Back-to-back: ready and ack tied high from WAIT at pc 0; valid every 2nd cycle.
    for (int i = 0; i < 8; i++) begin
      vec_t v;
      v.rst = 0; v.rdy = 1; v.rdata = 32'h0000_0020; v.ack = 1;
      v.pcSrc = 2'b00; v.br = 0; v.zero = 0; v.jrTgt = 32'h0;
      v.expReq = 0; v.expValid = 0; v.expInstr = 0; v.expPc = 0;
      applyStimulus(v);
      checkOutput($sformatf("b2b%0d inst_valid", i), {31'b0, inst_valid},
                  {31'b0, ((i % 2) == 0)});
      checkOutput($sformatf("b2b%0d pc", i), pc, 32'(4 * ((i + 1) / 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction fetch and program-counter unit for the multi-cycle MIPS core. It owns the PC, fetches instruction words from instruction memory over a req/ready handshake, and presents each word to the control decoder by driving OpCode/Funct. It consumes the decoder's PCSrc/Branch outputs together with the ALU Zero flag to select the next PC, so it is the producer of OpCode/Funct and the consumer of PCSrc/Branch.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; high only in WAIT.
- imem_addr  out  32  fetch address; equals pc.
- imem_ready  in  1  memory response valid; sampled only while imem_req=1.
- imem_rdata  in  32  instruction word; captured when imem_req && imem_ready.
- inst_valid  out  1  instruction register holds an unconsumed instruction.
- instruction  out  32  registered instruction word.
- OpCode  out  6  instruction[31:26], to the control decoder.
- Funct  out  6  instruction[5:0], to the control decoder.
- inst_ack  in  1  execute stage retires the current instruction; the next PC is taken this cycle.
- PCSrc  in  2  from decoder: 00 sequential/branch, 01 j/jal, 10 jr/jalr, 11 treated as 00 without branch.
- Branch  in  1  from decoder, beq.
- Zero  in  1  ALU equality result for the current instruction.
- jr_target  in  32  rs register value for jr/jalr.
- pc  out  32  current PC.
- pc_plus4  out  32  pc + 4, used as the link value for jal/jalr.

## Operation
- States: IDLE, WAIT, HOLD.
- IDLE: entered on reset; lasts exactly 1 cycle; then goes to WAIT.
- WAIT: imem_req=1, imem_addr=pc. On imem_ready=1: instruction <= imem_rdata, inst_valid <= 1, go to HOLD. Otherwise remain in WAIT with address stable.
- HOLD: inst_valid=1, instruction stable. On inst_ack=1: pc <= next_pc, inst_valid <= 0, go to WAIT.
- inst_ack outside HOLD is ignored. imem_ready outside WAIT is ignored.
- next_pc:
  - PCSrc=01: {pc_plus4[31:28], instruction[25:0], 2'b00}.
  - PCSrc=10: {jr_target[31:2], 2'b00}. The low bits are forced to zero.
  - PCSrc=00 with Branch && Zero: pc_plus4 + (sign-extended instruction[15:0] << 2).
  - All other cases: pc_plus4.
- All arithmetic is 32-bit modulo 2^32. pc=32'hFFFF_FFFC gives pc_plus4=0. Branch targets wrap silently.
- OpCode, Funct and pc_plus4 are combinational from the registers.
- While inst_valid=0, instruction keeps its last value. After reset it is 0, which decodes as sll $0 (a nop).

## Timing
- Reset values: pc=RESET_PC, instruction=0, inst_valid=0, imem_req=0, state=IDLE.
- Reset has priority over every other input in the same cycle.
- Reset asserted in WAIT abandons the pending fetch. A later imem_ready is ignored until the next WAIT.
- Cycle after reset deasserts: IDLE. Next cycle: WAIT with imem_req=1, imem_addr=RESET_PC.
- Zero-wait memory (ready in the first WAIT cycle): inst_valid rises 1 cycle after the request.
- With inst_ack in the first HOLD cycle, the next request issues the following cycle. Peak throughput is 1 instruction per 2 cycles.
- N wait cycles (ready low) add N cycles. imem_addr is held constant throughout.
- PCSrc, Branch, Zero and jr_target are sampled only in the cycle where inst_ack=1 in HOLD.

## Structure
- Shared package cpu_pkg:
  - opcode constants OP_J=6'h02, OP_JAL=6'h03, OP_BEQ=6'h04;
  - PCSrc encodings PCSRC_SEQ=2'b00, PCSRC_JUMP=2'b01, PCSRC_JR=2'b10;
  - fetch state enum.
- One combinational sub-module, next_pc_calc: inputs pc_plus4, instruction, PCSrc, Branch, Zero, jr_target; output next_pc.
- The FSM and registers live in pc_fetch_unit.

## Test plan
- Reset, then ready tied high, rdata=32'h0000_0020, inst_ack in each HOLD:
  - imem_addr sequence 0x0, 0x4, 0x8;
  - inst_valid pulses every 2nd cycle;
  - OpCode=0, Funct=6'h20.
- Jump: pc=0x0000_0010, instruction 32'h0800_0040 (j), PCSrc=01, ack → next imem_addr=0x0000_0100.
- beq: pc=0x20, imm=16'hFFFE.
  - With Branch=1, Zero=1, ack → next pc=0x1C.
  - Repeat with Zero=0 → next pc=0x24.
- jr: jr_target=0x0000_0123, PCSrc=10, ack → next pc=0x0000_0120.
- Wait states and abort:
  - Ready held low for 3 cycles → imem_addr stable, inst_valid=0; capture on the 4th cycle.
  - Reset asserted in WAIT → pc=RESET_PC, inst_valid=0, and a stale ready in the next cycle is ignored.
- Wrap and ignored ack:
  - pc=0xFFFF_FFFC, sequential ack → next pc=0x0.
  - inst_ack asserted during WAIT → no pc change.
